// File: rtl/reg_file_if.sv
// Bus bundle for reg_file: one write port, two combinational read ports and the wr_err flag.
// There is no valid/ready handshake. we qualifies a write at the rising edge, clr overrides it,
// and the read data follows the read addresses with no handshake.
interface reg_file_if #(
    parameter int WIDTH = 4,
    parameter int AW    = 2
);
    logic             clr;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic [AW-1:0]    raddr_a;
    logic [WIDTH-1:0] rdata_a;
    logic [AW-1:0]    raddr_b;
    logic [WIDTH-1:0] rdata_b;
    logic             wr_err;

    modport master (
        output clr, we, waddr, wdata, raddr_a, raddr_b,
        input  rdata_a, rdata_b, wr_err
    );

    modport slave (
        input  clr, we, waddr, wdata, raddr_a, raddr_b,
        output rdata_a, rdata_b, wr_err
    );
endinterface

// File: rtl/reg_file.sv
// DEPTH x WIDTH register file: synchronous write, two combinational reads, synchronous bulk clear.
// Optional macro REGFILE_BYPASS_EN adds write-first forwarding from wdata to the read ports.
module reg_file #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input logic      clk,
    input logic      rst_n,
    reg_file_if.slave bus
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             wr_err_q;
    logic             wr_err_d;
    logic             waddr_ok;
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;

    // Compare as int so DEPTH == 2**AW does not wrap to zero.
    assign waddr_ok = int'(bus.waddr) < DEPTH;

    always_comb begin
        mem_d    = mem_q;
        wr_err_d = wr_err_q;
        if (bus.clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
            wr_err_d = 1'b0;
        end else if (bus.we) begin
            wr_err_d = !waddr_ok;
            for (int i = 0; i < DEPTH; i++) begin
                if (waddr_ok && bus.waddr == AW'(i)) begin
                    mem_d[i] = bus.wdata;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_err_q <= wr_err_d;
        end
    end

    // Addresses at or beyond DEPTH match no entry and read as zero.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.raddr_a == AW'(i)) rd_a = mem_q[i];
            if (bus.raddr_b == AW'(i)) rd_b = mem_q[i];
        end
`ifdef REGFILE_BYPASS_EN
        if (!rst_n || bus.clr) begin
            rd_a = '0;
            rd_b = '0;
        end else if (bus.we && waddr_ok) begin
            if (bus.raddr_a == bus.waddr) rd_a = bus.wdata;
            if (bus.raddr_b == bus.waddr) rd_b = bus.wdata;
        end
`endif
    end

    assign bus.rdata_a = rd_a;
    assign bus.rdata_b = rd_b;
    assign bus.wr_err  = wr_err_q;
endmodule
